wb_retire_queue: RTL

WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

---
 rtl/wb_retire_queue_if.sv | 52 +++++
 rtl/wb_retire_queue.sv | 133 +++++++++++++
 2 files changed

// File: rtl/wb_retire_queue_if.sv
// Writeback retire-queue bundle: upstream entry handshake, register-file write,
// flush report and forwarding lookup.
interface wb_retire_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          ms_to_ws_valid;
    logic          ws_allowin;
    logic [31:0]   in_pc;
    logic          in_gr_we;
    logic [AW-1:0] in_dest;
    logic [DW-1:0] in_result;
    logic          in_ex;
    logic [4:0]    in_excode;
    logic          in_eret;

    logic          rf_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    logic          ws_flush;
    logic          flush_ex;
    logic          flush_eret;
    logic [31:0]   flush_pc;
    logic [4:0]    flush_excode;

    logic [AW-1:0] fwd_raddr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    logic [CW-1:0] occupancy;

    modport master (
        output ms_to_ws_valid, in_pc, in_gr_we, in_dest, in_result, in_ex, in_excode, in_eret,
        output rf_ready, fwd_raddr,
        input  ws_allowin, rf_we, rf_waddr, rf_wdata,
        input  ws_flush, flush_ex, flush_eret, flush_pc, flush_excode,
        input  fwd_hit, fwd_data, occupancy
    );

    modport slave (
        input  ms_to_ws_valid, in_pc, in_gr_we, in_dest, in_result, in_ex, in_excode, in_eret,
        input  rf_ready, fwd_raddr,
        output ws_allowin, rf_we, rf_waddr, rf_wdata,
        output ws_flush, flush_ex, flush_eret, flush_pc, flush_excode,
        output fwd_hit, fwd_data, occupancy
    );
endinterface

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: circular FIFO that retires one entry per cycle into the
// register file, raises a flush for exception/ERET entries, and forwards queued results.
module wb_retire_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              resetn,
    wb_retire_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0]   pc;
        logic          gr_we;
        logic [AW-1:0] dest;
        logic [DW-1:0] result;
        logic          ex;
        logic [4:0]    excode;
        logic          eret;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_occ;

    entry_t        w_in_ent;
    entry_t        w_head_ent;
    logic          w_pop;
    logic          w_push;
    logic          w_allowin;
    logic          w_flush;
    logic          w_rf_we;
    logic [PW-1:0] w_fwd_idx;
    logic          w_fwd_hit;
    logic [DW-1:0] w_fwd_data;

    assign w_in_ent = '{pc:     bus.in_pc,
                        gr_we:  bus.in_gr_we,
                        dest:   bus.in_dest,
                        result: bus.in_result,
                        ex:     bus.in_ex,
                        excode: bus.in_excode,
                        eret:   bus.in_eret};

    assign w_head_ent = r_mem[r_head];
    assign w_pop      = (r_occ != '0) && r_valid[r_head] && bus.rf_ready;
    assign w_allowin  = (r_occ < CW'(DEPTH)) || w_pop;
    assign w_push     = bus.ms_to_ws_valid && w_allowin;
    assign w_flush    = w_pop && (w_head_ent.ex || w_head_ent.eret);
    assign w_rf_we    = w_pop && w_head_ent.gr_we && !w_head_ent.ex && !w_head_ent.eret;

    // Pointer/occupancy state. A flush wins over any same-cycle push, which is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
        end else if (w_flush) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
        end else begin
            // NOTE: when full, push and pop hit the same slot; the later set must win.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: payload has no reset; every output that shows it is gated by a valid entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_in_ent;
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a latch.
        w_fwd_idx  = '0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (bus.fwd_raddr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_fwd_idx = r_head + PW'(i);
                if ((CW'(i) < r_occ) && r_valid[w_fwd_idx]
                    && r_mem[w_fwd_idx].gr_we && !r_mem[w_fwd_idx].ex && !r_mem[w_fwd_idx].eret
                    && (r_mem[w_fwd_idx].dest == bus.fwd_raddr)) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_mem[w_fwd_idx].result;
                end
            end
        end
    end

    always_comb begin
        bus.rf_we        = w_rf_we;
        bus.rf_waddr     = '0;
        bus.rf_wdata     = '0;
        bus.ws_flush     = w_flush;
        bus.flush_ex     = w_flush && w_head_ent.ex;
        bus.flush_eret   = w_flush && w_head_ent.eret && !w_head_ent.ex;
        bus.flush_pc     = '0;
        bus.flush_excode = '0;
        if (w_rf_we) begin
            bus.rf_waddr = w_head_ent.dest;
            bus.rf_wdata = w_head_ent.result;
        end
        if (w_flush) begin
            bus.flush_pc     = w_head_ent.pc;
            bus.flush_excode = w_head_ent.excode;
        end
    end

    assign bus.ws_allowin = w_allowin;
    assign bus.fwd_hit    = w_fwd_hit;
    assign bus.fwd_data   = w_fwd_data;
    assign bus.occupancy  = r_occ;

endmodule
